// File: rtl/controller_pkg.sv
// Shared controller definitions: transfer length width and the TX byte
// unpacker state encoding, plus the byte-lane select used by the unpacker.
package controller_pkg;

  // Width of the HCI data_length field, shared with the flow FSM.
  localparam int unsigned DATA_LEN_WIDTH = 16;

  typedef enum logic [1:0] {
    TX_UNPACK_IDLE  = 2'd0,
    TX_UNPACK_FETCH = 2'd1,
    TX_UNPACK_EMIT  = 2'd2,
    TX_UNPACK_DONE  = 2'd3
  } tx_unpack_state_e;

  // 4:1 byte-lane mux over a little-endian 32-bit word.
  function automatic logic [7:0] tx_select_byte(input logic [31:0] word,
                                                input logic [1:0]  idx);
    logic [7:0] sel;
    case (idx)
      2'd0:    sel = word[7:0];
      2'd1:    sel = word[15:8];
      2'd2:    sel = word[23:16];
      default: sel = word[31:24];
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/i3c_tx_byte_unpacker.sv
// Splits 32-bit little-endian TX queue words into a byte stream for the
// I3C controller. One private-write transfer at a time; pops exactly
// ceil(len/4) words, discarding unused upper bytes of the final word.
module i3c_tx_byte_unpacker
  import controller_pkg::*;
#(
  parameter int unsigned TxDataWidth = 32,
  parameter int unsigned LenWidth    = DATA_LEN_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [LenWidth-1:0]    data_len_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   aborted_o,
  output logic [LenWidth-1:0]    bytes_sent_o,
  input  logic                   tx_queue_rvalid_i,
  output logic                   tx_queue_rready_o,
  input  logic [TxDataWidth-1:0] tx_queue_rdata_i,
  output logic                   byte_valid_o,
  input  logic                   byte_ready_i,
  output logic [7:0]             byte_o,
  output logic                   byte_last_o
);

  localparam logic [LenWidth-1:0] LenOne  = LenWidth'(1);
  localparam logic [LenWidth-1:0] LenZero = LenWidth'(0);

  tx_unpack_state_e     state_q, state_d;
  logic [LenWidth-1:0]  remaining_q, remaining_d;
  logic [LenWidth-1:0]  bytes_sent_q, bytes_sent_d;
  logic [1:0]           idx_q, idx_d;
  logic [TxDataWidth-1:0] word_q, word_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;
  logic                 byte_valid_q, byte_valid_d;
  logic [7:0]           byte_q, byte_d;
  logic                 byte_last_q, byte_last_d;
  logic                 byte_hs;

  // A byte moves whenever we are presenting one and downstream takes it.
  assign byte_hs = (state_q == TX_UNPACK_EMIT) && byte_ready_i;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    bytes_sent_d = bytes_sent_q;
    idx_d        = idx_q;
    word_d       = word_q;
    aborted_d    = 1'b0;

    case (state_q)
      TX_UNPACK_IDLE: begin
        if (start_i) begin
          remaining_d  = data_len_i;
          bytes_sent_d = LenZero;
          if (data_len_i == LenZero) begin
            state_d = TX_UNPACK_DONE;
          end else begin
            state_d = TX_UNPACK_FETCH;
          end
        end else begin
          state_d = TX_UNPACK_IDLE;
        end
      end
      TX_UNPACK_FETCH: begin
        if (tx_queue_rvalid_i) begin
          word_d  = tx_queue_rdata_i;
          idx_d   = 2'd0;
          state_d = TX_UNPACK_EMIT;
        end else begin
          state_d = TX_UNPACK_FETCH;
        end
      end
      TX_UNPACK_EMIT: begin
        if (byte_hs) begin
          remaining_d  = remaining_q - LenOne;
          bytes_sent_d = bytes_sent_q + LenOne;
          idx_d        = idx_q + 2'd1;
          if (remaining_q == LenOne) begin
            state_d = TX_UNPACK_DONE;
          end else if (idx_q == 2'd3) begin
            state_d = TX_UNPACK_FETCH;
          end else begin
            state_d = TX_UNPACK_EMIT;
          end
        end else begin
          state_d = TX_UNPACK_EMIT;
        end
      end
      TX_UNPACK_DONE: begin
        state_d = TX_UNPACK_IDLE;
      end
      default: begin
        state_d = TX_UNPACK_IDLE;
      end
    endcase

    // Abort overrides any transition out of an active state; the byte
    // counter update above is kept so a same-cycle handshake still counts.
    if (abort_i && (state_q != TX_UNPACK_IDLE)) begin
      state_d   = TX_UNPACK_IDLE;
      aborted_d = 1'b1;
    end else begin
      aborted_d = 1'b0;
    end

    busy_d       = (state_d != TX_UNPACK_IDLE);
    done_d       = (state_d == TX_UNPACK_DONE);
    byte_valid_d = (state_d == TX_UNPACK_EMIT);
    if (state_d == TX_UNPACK_EMIT) begin
      byte_d      = tx_select_byte(word_d[31:0], idx_d);
      byte_last_d = (remaining_d == LenOne);
    end else begin
      byte_d      = 8'h00;
      byte_last_d = 1'b0;
    end
  end

  // State, counters, word holding register and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= TX_UNPACK_IDLE;
      remaining_q  <= LenZero;
      bytes_sent_q <= LenZero;
      idx_q        <= 2'd0;
      word_q       <= {TxDataWidth{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_q       <= 8'h00;
      byte_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      bytes_sent_q <= bytes_sent_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      byte_last_q  <= byte_last_d;
    end
  end

  // Pop strobe depends on state only, never on rvalid.
  assign tx_queue_rready_o = (state_q == TX_UNPACK_FETCH);
  assign busy_o            = busy_q;
  // An abort landing in DONE suppresses the completion pulse.
  assign done_o            = done_q & ~abort_i;
  assign aborted_o         = aborted_q;
  assign bytes_sent_o      = bytes_sent_q;
  assign byte_valid_o      = byte_valid_q;
  assign byte_o            = byte_q;
  assign byte_last_o       = byte_last_q;

endmodule

// File: tb/tb_i3c_tx_byte_unpacker.sv
// Directed bench for i3c_tx_byte_unpacker with a TX queue model and a
// byte/event monitor; expected values are written out by hand per test.
module tb_i3c_tx_byte_unpacker;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] data_len_i = 16'd0;
  logic        abort_i = 1'b0;
  logic        busy_o, done_o, aborted_o;
  logic [15:0] bytes_sent_o;
  logic        tx_queue_rvalid_i, tx_queue_rready_o;
  logic [31:0] tx_queue_rdata_i;
  logic        byte_valid_o;
  logic        byte_ready_i = 1'b0;
  logic [7:0]  byte_o;
  logic        byte_last_o;

  int n_vec  = 0;
  int n_miss = 0;

  // queue model
  logic [31:0] qmem [4];
  logic [2:0]  qlen = 3'd0;
  logic [2:0]  qptr;

  // monitor state
  logic        clr = 1'b0;
  int          cyc = 0;
  logic [7:0]  cap_byte [16];
  logic        cap_last [16];
  int          ncap, pops, done_cnt, ab_cnt, stable_err;
  int          start_cyc, first_valid_cyc, last_hs_cyc, done_cyc;
  logic        rready_seen, valid_seen, prev_stall, prev_done, busy_after_done;
  logic [7:0]  prev_byte;
  logic        prev_last;

  always #5 clk_i = ~clk_i;

  assign tx_queue_rvalid_i = (qptr < qlen);
  assign tx_queue_rdata_i  = (qptr < 3'd4) ? qmem[qptr[1:0]] : 32'h0;

  i3c_tx_byte_unpacker #(.TxDataWidth(32), .LenWidth(16)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .start_i           (start_i),
    .data_len_i        (data_len_i),
    .abort_i           (abort_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .aborted_o         (aborted_o),
    .bytes_sent_o      (bytes_sent_o),
    .tx_queue_rvalid_i (tx_queue_rvalid_i),
    .tx_queue_rready_o (tx_queue_rready_o),
    .tx_queue_rdata_i  (tx_queue_rdata_i),
    .byte_valid_o      (byte_valid_o),
    .byte_ready_i      (byte_ready_i),
    .byte_o            (byte_o),
    .byte_last_o       (byte_last_o)
  );

  // Monitor: records handshakes, pops and event timing at each edge.
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (clr) begin
      qptr <= 3'd0; ncap <= 0; pops <= 0; done_cnt <= 0; ab_cnt <= 0;
      stable_err <= 0; start_cyc <= -1; first_valid_cyc <= -1;
      last_hs_cyc <= -1; done_cyc <= -1; rready_seen <= 1'b0;
      valid_seen <= 1'b0; prev_stall <= 1'b0; prev_done <= 1'b0;
      busy_after_done <= 1'b1; prev_byte <= 8'h00; prev_last <= 1'b0;
    end else begin
      if (start_i && !busy_o) start_cyc <= cyc;
      if (tx_queue_rready_o) rready_seen <= 1'b1;
      if (tx_queue_rready_o && tx_queue_rvalid_i) begin
        pops <= pops + 1;
        qptr <= qptr + 3'd1;
      end
      if (byte_valid_o) begin
        valid_seen <= 1'b1;
        if (first_valid_cyc < 0) first_valid_cyc <= cyc;
      end
      if (prev_stall && (!byte_valid_o || byte_o != prev_byte || byte_last_o != prev_last))
        stable_err <= stable_err + 1;
      prev_stall <= byte_valid_o && !byte_ready_i;
      prev_byte  <= byte_o;
      prev_last  <= byte_last_o;
      if (byte_valid_o && byte_ready_i) begin
        if (ncap < 16) begin
          cap_byte[ncap] <= byte_o;
          cap_last[ncap] <= byte_last_o;
        end
        ncap <= ncap + 1;
        if (byte_last_o) last_hs_cyc <= cyc;
      end
      if (done_o) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (aborted_o) ab_cnt <= ab_cnt + 1;
      if (prev_done) busy_after_done <= busy_o;
      prev_done <= done_o;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge clk_i); clr = 1'b1;
    @(negedge clk_i); clr = 1'b0;
  endtask

  task automatic start_xfer(input logic [15:0] len);
    @(negedge clk_i); start_i = 1'b1; data_len_i = len;
    @(negedge clk_i); start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 500; k++) begin
      if (!busy_o) break;
      @(negedge clk_i);
    end
    check_eq(tag, {31'd0, busy_o}, 32'd0);
    repeat (2) @(negedge clk_i);
  endtask

  // exp holds byte i at [8*i +: 8]; last flag expected only on byte n-1.
  task automatic check_bytes(input string tag, input logic [63:0] exp, input int n);
    check_eq({tag, "_count"}, ncap, n);
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_byte%0d", tag, i), {24'd0, cap_byte[i]}, {24'd0, exp[8*i +: 8]});
      check_eq($sformatf("%s_last%0d", tag, i), {31'd0, cap_last[i]}, (i == n - 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    qmem[0] = 32'h0; qmem[1] = 32'h0; qmem[2] = 32'h0; qmem[3] = 32'h0;
    clr = 1'b1;
    repeat (3) @(negedge clk_i);
    // reset state
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_valid", {31'd0, byte_valid_o}, 32'd0);
    check_eq("rst_rready", {31'd0, tx_queue_rready_o}, 32'd0);
    check_eq("rst_done", {31'd0, done_o}, 32'd0);
    check_eq("rst_aborted", {31'd0, aborted_o}, 32'd0);
    check_eq("rst_sent", {16'd0, bytes_sent_o}, 32'd0);
    check_eq("rst_byte", {23'd0, byte_last_o, byte_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i); clr = 1'b0;

    // T1: len=4, single word, ready always high
    qmem[0] = 32'h44332211; qlen = 3'd1; byte_ready_i = 1'b1;
    clear_mon();
    start_xfer(16'd4);
    wait_idle("t1_idle");
    check_bytes("t1", 64'h0000_0000_4433_2211, 4);
    check_eq("t1_pops", pops, 32'd1);
    check_eq("t1_done_cnt", done_cnt, 32'd1);
    check_eq("t1_first_valid", first_valid_cyc, start_cyc + 2);
    check_eq("t1_done_timing", done_cyc, last_hs_cyc + 1);
    check_eq("t1_busy_after_done", {31'd0, busy_after_done}, 32'd0);
    check_eq("t1_sent", {16'd0, bytes_sent_o}, 32'd4);

    // T2: len=6 across two words, upper two bytes of word 2 discarded
    qmem[0] = 32'h44332211; qmem[1] = 32'hDDCCBB55; qlen = 3'd2;
    clear_mon();
    start_xfer(16'd6);
    wait_idle("t2_idle");
    check_bytes("t2", 64'h0000_BB55_4433_2211, 6);
    check_eq("t2_pops", pops, 32'd2);
    check_eq("t2_sent", {16'd0, bytes_sent_o}, 32'd6);
    check_eq("t2_done_cnt", done_cnt, 32'd1);

    // T3: len=0 completes immediately without touching the queue
    qlen = 3'd2;
    clear_mon();
    start_xfer(16'd0);
    wait_idle("t3_idle");
    check_eq("t3_done_timing", done_cyc, start_cyc + 1);
    check_eq("t3_done_cnt", done_cnt, 32'd1);
    check_eq("t3_rready_seen", {31'd0, rready_seen}, 32'd0);
    check_eq("t3_valid_seen", {31'd0, valid_seen}, 32'd0);
    check_eq("t3_pops", pops, 32'd0);
    check_eq("t3_sent", {16'd0, bytes_sent_o}, 32'd0);

    // T4: len=8, ready toggling, second word held back
    qmem[0] = 32'h04030201; qmem[1] = 32'h08070605; qlen = 3'd1;
    byte_ready_i = 1'b0;
    clear_mon();
    start_xfer(16'd8);
    fork
      begin
        for (int k = 0; k < 400 && busy_o; k++) begin
          @(negedge clk_i);
          byte_ready_i = ~byte_ready_i;
        end
      end
      begin
        for (int k = 0; k < 200 && pops < 1; k++) @(negedge clk_i);
        repeat (14) @(negedge clk_i);
        qlen = 3'd2;
      end
    join
    byte_ready_i = 1'b1;
    wait_idle("t4_idle");
    check_bytes("t4", 64'h0807_0605_0403_0201, 8);
    check_eq("t4_stable", stable_err, 32'd0);
    check_eq("t4_pops", pops, 32'd2);
    check_eq("t4_done_cnt", done_cnt, 32'd1);
    check_eq("t4_sent", {16'd0, bytes_sent_o}, 32'd8);

    // T5: abort after two of eight bytes
    qmem[0] = 32'h04030201; qmem[1] = 32'h08070605; qlen = 3'd2;
    byte_ready_i = 1'b1;
    clear_mon();
    start_xfer(16'd8);
    for (int k = 0; k < 100 && ncap < 2; k++) @(negedge clk_i);
    byte_ready_i = 1'b0; abort_i = 1'b1;
    @(negedge clk_i); abort_i = 1'b0;
    check_eq("t5_busy_low", {31'd0, busy_o}, 32'd0);
    check_eq("t5_aborted_pulse", {31'd0, aborted_o}, 32'd1);
    @(negedge clk_i);
    check_eq("t5_aborted_once", {31'd0, aborted_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    check_eq("t5_ab_cnt", ab_cnt, 32'd1);
    check_eq("t5_done_cnt", done_cnt, 32'd0);
    check_eq("t5_sent", {16'd0, bytes_sent_o}, 32'd2);
    check_eq("t5_pops", pops, 32'd1);

    // abort while idle has no effect
    clear_mon();
    @(negedge clk_i); abort_i = 1'b1;
    @(negedge clk_i); abort_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_eq("idle_abort", ab_cnt, 32'd0);

    // T6: second start while busy is ignored
    qmem[0] = 32'hAABBCCDD; qmem[1] = 32'h11111111; qlen = 3'd2;
    byte_ready_i = 1'b1;
    clear_mon();
    start_xfer(16'd4);
    @(negedge clk_i); start_i = 1'b1; data_len_i = 16'd8;
    @(negedge clk_i); start_i = 1'b0;
    wait_idle("t6_idle");
    check_bytes("t6", 64'h0000_0000_AABB_CCDD, 4);
    check_eq("t6_pops", pops, 32'd1);
    check_eq("t6_done_cnt", done_cnt, 32'd1);
    check_eq("t6_sent", {16'd0, bytes_sent_o}, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
